// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file slave: FSM state encoding,
// address-decode constants and the word-index / error decode helper.
package apb_pkg;

    // Transfer FSM states
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        ACCESS
    } apbState_t;

    // Registers are word aligned, so the two low address bits select a byte
    localparam int ADDR_LSB = 2;

    // Largest number of wait states the 4-bit wait counter can express
    localparam int MAX_WAIT = 15;

    // Result of decoding a byte address into a register slot
    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } addrDecode_t;

    // Word index is the address shifted down by ADDR_LSB; the access is
    // rejected when it is not word aligned or points past the last register.
    function automatic addrDecode_t decodeAddr(input logic [63:0] addr,
                                               input int unsigned numRegs);
        addrDecode_t res;
        logic [63:0] wordIdx;
        wordIdx = addr >> ADDR_LSB;
        res.idx = wordIdx[31:0];
        res.err = (addr[ADDR_LSB-1:0] != '0) || (wordIdx >= 64'(numRegs));
        return res;
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter for the APB register-file slave. Cleared when a new
// transfer starts, counts while the transfer is stretched and raises done
// once it has reached WAIT_CYCLES-1, holding there until the next clear.
module apb_wait_ctr
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority over counting so a back-to-back transfer restarts at 0
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == LAST);

endmodule

// File: rtl/apb_regfile_slave.sv
// Parametrised APB slave register file: NUM_REGS word registers, WAIT_CYCLES
// stretched access phases and PSLVERR on misaligned or out-of-range addresses.
// Defining APB_REGFILE_PSTRB_EN adds the PSTRB port and byte-lane writes.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_REGS    = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apbState_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic              write_q, write_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] regFile_q [NUM_REGS];
    logic [DATA_W-1:0] regFile_d [NUM_REGS];

    addrDecode_t       liveDec;
    logic [IDX_W-1:0]  liveIdx;
    logic              startXfer;
    logic              inXfer;
    logic              waitDone;
    logic              writeEn;

    assign liveDec = decodeAddr(64'(PADDR), NUM_REGS);
    assign liveIdx = IDX_W'(liveDec.idx);

    // A setup phase is accepted only while no transfer is in flight
    assign startXfer = ((state_q == IDLE) || (state_q == ACCESS)) && PSEL && !PENABLE;
    assign inXfer    = (state_q == SETUP) || (state_q == WAIT);
    assign writeEn   = PSEL && PENABLE && pready_q && write_q && PWRITE && !err_q;

    generate
        if (WAIT_CYCLES > 0) begin : gWait
            apb_wait_ctr #(
                .WAIT_CYCLES(WAIT_CYCLES)
            ) uWaitCtr (
                .clk_i   (PCLK),
                .reset_i (PRESET),
                .clear_i (startXfer),
                .enable_i(inXfer && !waitDone),
                .done_o  (waitDone)
            );
        end else begin : gNoWait
            assign waitDone = 1'b1;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; WAIT is left only after the ready beat has been shown
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCESS: state_d = startXfer ? SETUP : IDLE;
            SETUP: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (WAIT_CYCLES == 0) begin
                    state_d = ACCESS;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (waitDone && pready_q) begin
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: decode is captured at setup and the response is precomputed
    always_comb begin
        idx_d   = startXfer ? liveIdx     : idx_q;
        err_d   = startXfer ? liveDec.err : err_q;
        write_d = startXfer ? PWRITE      : write_q;
        if (WAIT_CYCLES == 0) begin
            pready_d = startXfer;
        end else begin
            pready_d = inXfer && PSEL && waitDone && !pready_q;
        end
        pslverr_d = pready_d && err_d;
        prdata_d  = '0;
        if (pready_d && !err_d && !write_d) begin
            prdata_d = regFile_q[idx_d];
        end
    end

    // Register array update on the completing edge of a good write
    always_comb begin
        regFile_d = regFile_q;
        if (writeEn) begin
`ifdef APB_REGFILE_PSTRB_EN
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (PSTRB[b]) begin
                    regFile_d[idx_q][8*b +: 8] = PWDATA[8*b +: 8];
                end
            end
`else
            regFile_d[idx_q] = PWDATA;
`endif
        end
    end

    // Datapath and response registers, all cleared by reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            idx_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regFile_q[r] <= '0;
            end
        end else begin
            idx_q     <= idx_d;
            err_q     <= err_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regFile_q <= regFile_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB slave register file, successor to the fixed four-register student-data slave. It sits behind the team's APB master on the shared PCLK bus segment. It provides NUM_REGS word registers, a configurable number of wait states, and an error response on bad addresses. Optionally it supports byte-lane write strobes.

## Interface
Parameters:
- DATA_W, 32, data bus width; must be a multiple of 8
- ADDR_W, 32, address bus width
- NUM_REGS, 4, number of DATA_W-bit registers at byte offsets 0, 4, 8, …
- WAIT_CYCLES, 0, PREADY-low cycles inserted in every ACCESS phase (0–15)

Ports (one clock; reset is synchronous and active-high):
- PCLK  in  1  bus clock; all logic on rising edge
- PRESET  in  1  synchronous active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase strobe
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PSTRB  in  DATA_W/8  byte-lane enables; present only with APB_REGFILE_PSTRB_EN
- PRDATA  out  DATA_W  read data; registered
- PREADY  out  1  transfer complete; registered
- PSLVERR  out  1  error response; valid only while PREADY=1

## Operation
- FSM states: IDLE, SETUP, WAIT, ACCESS.
  - IDLE→SETUP on PSEL=1 & PENABLE=0.
  - SETUP→WAIT if WAIT_CYCLES>0, else SETUP→ACCESS.
  - WAIT→ACCESS when the wait counter reaches WAIT_CYCLES−1.
  - ACCESS→SETUP if the next cycle shows PSEL=1 & PENABLE=0 (back-to-back), else ACCESS→IDLE.
- Address decode happens on entry to SETUP.
  - idx = PADDR >> 2.
  - Error if PADDR[1:0]≠0 or idx ≥ NUM_REGS.
- Write commits on the edge where PSEL & PENABLE & PREADY & PWRITE & !error. Only that edge writes.
- Read: PRDATA loads reg[idx] on the cycle PREADY rises. PRDATA is 0 when PREADY=0 or on error.
- Error transfer: no register changes, PRDATA=0, PSLVERR=1 together with PREADY.
- PSEL deasserted before completion (abort): FSM→IDLE next cycle, no write, PREADY stays 0.
- PENABLE=1 seen in IDLE (no setup phase): ignored, no response.
- Reset values: all registers 0, PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, wait counter=0.
- PRESET during any state: next edge FSM=IDLE, registers cleared, any pending write dropped.

## Timing
- Setup phase is cycle 0.
- PREADY=1 in cycle 1+WAIT_CYCLES, for exactly one cycle per transfer.
- WAIT_CYCLES=0 gives the zero-wait APB timing: 2 cycles per transfer.
- Write data is visible to a following read on the next transfer (no bypass needed).
- Back-to-back transfers take 2+WAIT_CYCLES cycles each, with no idle cycle between them.
- PRDATA and PSLVERR change only on the cycle PREADY rises and return to 0 the cycle after.

## Configuration
- APB_REGFILE_PSTRB_EN defined:
  - PSTRB port exists.
  - Writes update only bytes whose PSTRB bit is 1.
  - A write with PSTRB=0 completes with PREADY and no error, changing nothing.
- Undefined: no PSTRB port; every write updates the full word.

## Structure
- Package apb_pkg holds:
  - the FSM state enum (IDLE, SETUP, WAIT, ACCESS)
  - the ADDR_LSB=2 constant
  - a MAX_WAIT=15 constant
  - the helper function computing word index and error flag
- Sub-module apb_wait_ctr: 4-bit counter with load/clear that flags done at WAIT_CYCLES−1. The top instantiates it only when WAIT_CYCLES>0.
- Register array, FSM and read mux live in the top module.

## Test plan
- Default params: write 23 to 0x0 and 0x20122023 to 0x4, then read both → PRDATA 23 and 0x20122023; PSLVERR=0; PREADY high 1 cycle each, 2 cycles per transfer.
- WAIT_CYCLES=2: write 0x98A0A1A0 to 0x8 → PREADY low for 2 access cycles, high in cycle 3. Read of 0x8 returns 0x98A0A1A0 with the same latency.
- NUM_REGS=4: write to 0x10 and read 0x6 → PSLVERR=1 with PREADY, PRDATA=0. A following read of 0x0 returns its previous value unchanged.
- WAIT_CYCLES=3: write 0x85AAA0E2 to 0xC, drop PSEL after 1 wait cycle → no PREADY; read of 0xC returns 0. Then assert PRESET mid-wait of a write → next cycle PREADY=0, FSM IDLE, all registers 0.
- APB_REGFILE_PSTRB_EN: 0x4 holds 0x20122023; write 0xAABBCCDD with PSTRB=4'b0011 → read 0x2012CCDD. Write with PSTRB=0 → value unchanged, PSLVERR=0.
- Back-to-back writes to 0x0, 0x4, 0x8, 0xC with no idle cycles → four PREADY pulses 2 cycles apart; read-back of all four matches.
